// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - receive-side circular FIFO behind the UART receiver
//
// Purpose: captures one-cycle rx strobes into a DEPTH-entry ring buffer and
// gives the consumer a show-ahead read port with level, threshold interrupt and
// sticky overrun status.
//
// Ports:
//   clk         clock
//   rstn        synchronous active-low reset
//   i_clr       synchronous flush of pointers/level (ovr untouched)
//   i_rx_data   byte from receiver
//   i_rx_valid  one-cycle push strobe
//   i_rd_en     pop head entry
//   o_rd_data   head entry (show-ahead), 0 when empty
//   o_empty     level == 0
//   o_full      level == DEPTH
//   o_level     entries stored, 0..DEPTH
//   i_thr       interrupt threshold (0 disables)
//   o_thr_irq   level >= thr && thr != 0 (registered)
//   o_ovr       sticky overrun, push dropped while full
//   i_ovr_clr   clears o_ovr
module uart_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int DW    = 8,
  localparam int LW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          i_clr,
  input  logic [DW-1:0] i_rx_data,
  input  logic          i_rx_valid,
  input  logic          i_rd_en,
  output logic [DW-1:0] o_rd_data,
  output logic          o_empty,
  output logic          o_full,
  output logic [LW-1:0] o_level,
  input  logic [LW-1:0] i_thr,
  output logic          o_thr_irq,
  output logic          o_ovr,
  input  logic          i_ovr_clr
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic          r_empty;
  logic          r_full;
  logic          r_thr_irq;
  logic          r_ovr;

  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic [LW-1:0] w_level_nxt;

  // A pop frees a slot in the same cycle, so a push into a full FIFO is
  // accepted when it coincides with a pop.
  assign w_pop  = i_rd_en && !r_empty;
  assign w_push = i_rx_valid && (!r_full || w_pop);
  // Flush discards any concurrent push; that is not an overrun.
  assign w_drop = i_rx_valid && r_full && !w_pop && !i_clr;

  always_comb begin
    w_level_nxt = r_level;
    if (i_clr) begin
      w_level_nxt = '0;
    end else if (w_push && !w_pop) begin
      w_level_nxt = r_level + LW'(1);
    end else if (w_pop && !w_push) begin
      w_level_nxt = r_level - LW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_level   <= '0;
      r_empty   <= 1'b1;
      r_full    <= 1'b0;
      r_thr_irq <= 1'b0;
      r_ovr     <= 1'b0;
    end else begin
      if (i_clr) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_level   <= w_level_nxt;
      r_empty   <= (w_level_nxt == '0);
      r_full    <= (w_level_nxt == LW'(DEPTH));
      r_thr_irq <= (i_thr != '0) && (w_level_nxt >= i_thr);
      // Set wins over clear.
      if (w_drop) begin
        r_ovr <= 1'b1;
      end else if (i_ovr_clr) begin
        r_ovr <= 1'b0;
      end
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_push && !i_clr) begin
      r_mem[r_wr_ptr] <= i_rx_data;
    end
  end

  assign o_rd_data = r_empty ? '0 : r_mem[r_rd_ptr];
  assign o_empty   = r_empty;
  assign o_full    = r_full;
  assign o_level   = r_level;
  assign o_thr_irq = r_thr_irq;
  assign o_ovr     = r_ovr;

endmodule
